// File: rtl/tape_player_if.sv
// Byte-read port from the tape player to the RAM arbiter.
// Each request is held until a single-cycle ack returns the data.
interface tape_player_if #(
  parameter int unsigned ADDR_W = 25
);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_din;
  logic              mem_ack;

  modport master (
    output mem_rd,
    output mem_addr,
    input  mem_din,
    input  mem_ack
  );

  modport slave (
    input  mem_rd,
    input  mem_addr,
    output mem_din,
    output mem_ack
  );
endinterface

// File: rtl/tape_player.sv
// Plays a RAM byte image out as a bi-phase cassette signal: zero-byte preamble,
// sync byte, then data, MSB first, fetched one byte ahead of the shifter.
module tape_player #(
  parameter int unsigned ADDR_W       = 25,
  parameter int unsigned HALF_PERIOD  = 600,
  parameter int unsigned PREAMBLE_LEN = 256,
  parameter logic [7:0]  SYNC_BYTE    = 8'hE6
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ce,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       length,
  output logic              busy,
  output logic              done,
  output logic              underrun,
  output logic              tape_out,
  tape_player_if.master     mem
);

  localparam int unsigned CntW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int unsigned PreW = (PREAMBLE_LEN > 0) ? $clog2(PREAMBLE_LEN + 1) : 1;
  localparam logic [CntW-1:0] HalfReload = CntW'(HALF_PERIOD - 1);
  localparam logic [PreW-1:0] PreLoad    = PreW'(PREAMBLE_LEN);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StPre  = 3'd1;
  localparam logic [2:0] StSync = 3'd2;
  localparam logic [2:0] StData = 3'd3;
  localparam logic [2:0] StDone = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              phase_q, phase_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        hold_q, hold_d;
  logic              hold_vld_q, hold_vld_d;
  logic [PreW-1:0]   pre_q, pre_d;
  logic [15:0]       send_left_q, send_left_d;
  logic [15:0]       fetch_left_q, fetch_left_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              underrun_q, underrun_d;
  logic              stall_q, stall_d;
  logic              tape_q, tape_d;

  logic       ack_fire;
  logic       load_en;
  logic [7:0] load_byte;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    phase_d      = phase_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    hold_d       = hold_q;
    hold_vld_d   = hold_vld_q;
    pre_d        = pre_q;
    send_left_d  = send_left_q;
    fetch_left_d = fetch_left_q;
    rd_d         = rd_q;
    addr_d       = addr_q;
    underrun_d   = underrun_q;
    stall_d      = stall_q;
    tape_d       = tape_q;
    load_en      = 1'b0;
    load_byte    = hold_q;
    ack_fire     = mem.mem_ack & rd_q;

    if (ack_fire) begin
      rd_d       = 1'b0;
      hold_d     = mem.mem_din;
      hold_vld_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d      = (PREAMBLE_LEN != 0) ? StPre : StSync;
          pre_d        = PreLoad;
          underrun_d   = 1'b0;
          stall_d      = 1'b0;
          hold_vld_d   = 1'b0;
          send_left_d  = length;
          fetch_left_d = (length != 16'd0) ? length - 16'd1 : 16'd0;
          addr_d       = base_addr;
          rd_d         = (length != 16'd0);
          shift_d      = (PREAMBLE_LEN != 0) ? 8'h00 : SYNC_BYTE;
          tape_d       = (PREAMBLE_LEN != 0) ? 1'b1 : ~SYNC_BYTE[7];
          bit_d        = 3'd7;
          phase_d      = 1'b0;
          cnt_d        = HalfReload;
        end
      end
      StPre, StSync, StData: begin
        if (stall_q) begin
          // Resume straight from the ack data rather than via the holding register.
          if (ack_fire) begin
            load_en   = 1'b1;
            load_byte = mem.mem_din;
          end
        end else if (ce) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CntW'(1);
          end else begin
            cnt_d = HalfReload;
            if (!phase_q) begin
              phase_d = 1'b1;
              tape_d  = shift_q[7];
            end else if (bit_q != 3'd0) begin
              shift_d = {shift_q[6:0], 1'b0};
              bit_d   = bit_q - 3'd1;
              phase_d = 1'b0;
              tape_d  = ~shift_q[6];
            end else if (state_q == StPre) begin
              bit_d   = 3'd7;
              phase_d = 1'b0;
              if (pre_q > PreW'(1)) begin
                pre_d   = pre_q - PreW'(1);
                shift_d = 8'h00;
                tape_d  = 1'b1;
              end else begin
                state_d = StSync;
                shift_d = SYNC_BYTE;
                tape_d  = ~SYNC_BYTE[7];
              end
            end else if (send_left_q == 16'd0) begin
              state_d = StDone;
              tape_d  = 1'b0;
            end else if (hold_vld_q || ack_fire) begin
              load_en   = 1'b1;
              load_byte = hold_vld_q ? hold_q : mem.mem_din;
            end else begin
              // Byte not back yet: freeze the line level and the half-bit timer.
              state_d    = StData;
              stall_d    = 1'b1;
              underrun_d = 1'b1;
            end
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (load_en) begin
      state_d     = StData;
      shift_d     = load_byte;
      bit_d       = 3'd7;
      phase_d     = 1'b0;
      cnt_d       = HalfReload;
      tape_d      = ~load_byte[7];
      hold_vld_d  = 1'b0;
      stall_d     = 1'b0;
      send_left_d = send_left_q - 16'd1;
      if (fetch_left_q != 16'd0) begin
        rd_d         = 1'b1;
        addr_d       = addr_q + ADDR_W'(1);
        fetch_left_d = fetch_left_q - 16'd1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      phase_q      <= 1'b0;
      bit_q        <= 3'd0;
      shift_q      <= 8'h00;
      hold_q       <= 8'h00;
      hold_vld_q   <= 1'b0;
      pre_q        <= '0;
      send_left_q  <= 16'd0;
      fetch_left_q <= 16'd0;
      rd_q         <= 1'b0;
      addr_q       <= '0;
      underrun_q   <= 1'b0;
      stall_q      <= 1'b0;
      tape_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_vld_q   <= hold_vld_d;
      pre_q        <= pre_d;
      send_left_q  <= send_left_d;
      fetch_left_q <= fetch_left_d;
      rd_q         <= rd_d;
      addr_q       <= addr_d;
      underrun_q   <= underrun_d;
      stall_q      <= stall_d;
      tape_q       <= tape_d;
    end
  end

  assign busy         = (state_q == StPre) || (state_q == StSync) || (state_q == StData);
  assign done         = (state_q == StDone);
  assign underrun     = underrun_q;
  assign tape_out     = tape_q;
  assign mem.mem_rd   = rd_q;
  assign mem.mem_addr = addr_q;

endmodule

// File: tb/tb_tape_player.sv
// Directed bench: dut_a (HALF_PERIOD=2, PREAMBLE_LEN=1) with a latency-programmable RAM,
// dut_b (HALF_PERIOD=3, PREAMBLE_LEN=2) for zero-length frames and slow ce.
module tb_tape_player;
  localparam int unsigned AW = 25;
  localparam int Never = 1 << 30;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic          reset;
  logic          a_ce, a_start, a_busy, a_done, a_underrun, a_tape;
  logic [AW-1:0] a_base;
  logic [15:0]   a_len;
  logic          b_ce, b_start, b_busy, b_done, b_underrun, b_tape;
  logic [AW-1:0] b_base;
  logic [15:0]   b_len;

  tape_player_if #(.ADDR_W(AW)) a_mem ();
  tape_player_if #(.ADDR_W(AW)) b_mem ();

  tape_player #(.ADDR_W(AW), .HALF_PERIOD(2), .PREAMBLE_LEN(1), .SYNC_BYTE(8'hE6)) dut_a (
    .clk_sys(clk_sys), .reset(reset), .ce(a_ce), .start(a_start), .base_addr(a_base),
    .length(a_len), .busy(a_busy), .done(a_done), .underrun(a_underrun), .tape_out(a_tape),
    .mem(a_mem)
  );

  tape_player #(.ADDR_W(AW), .HALF_PERIOD(3), .PREAMBLE_LEN(2), .SYNC_BYTE(8'hE6)) dut_b (
    .clk_sys(clk_sys), .reset(reset), .ce(b_ce), .start(b_start), .base_addr(b_base),
    .length(b_len), .busy(b_busy), .done(b_done), .underrun(b_underrun), .tape_out(b_tape),
    .mem(b_mem)
  );

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0] exp_bytes[$];

  function automatic logic [7:0] ram(input logic [AW-1:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  // RAM responder for dut_a: ack arrives a_lat cycles after a request is first seen.
  int            a_lat = 3;
  bit            a_pend = 1'b0;
  int            a_cnt = 0;
  logic          a_ack = 1'b0;
  logic [7:0]    a_din = 8'h00;
  logic [AW-1:0] a_req = '0;
  logic [AW-1:0] a_log[$];
  assign a_mem.mem_ack = a_ack;
  assign a_mem.mem_din = a_din;

  always @(negedge clk_sys) begin
    if (a_ack) begin
      a_ack = 1'b0;
    end else begin
      if (!a_pend && a_mem.mem_rd === 1'b1) begin
        a_pend = 1'b1;
        a_cnt  = a_lat;
        a_req  = a_mem.mem_addr;
        a_log.push_back(a_mem.mem_addr);
      end
      if (a_pend) begin
        if (a_cnt == 0) begin
          a_ack  = 1'b1;
          a_din  = ram(a_req);
          a_pend = 1'b0;
        end else begin
          a_cnt--;
        end
      end
    end
  end

  int b_rd_cnt = 0;
  assign b_mem.mem_ack = 1'b0;
  assign b_mem.mem_din = 8'h00;
  always @(negedge clk_sys) if (b_mem.mem_rd === 1'b1) b_rd_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Expected level of half-bit h of the frame held in exp_bytes.
  function automatic logic lvl(input int h);
    logic [7:0] b;
    int         k;
    b = exp_bytes[h / 16];
    k = 7 - (h % 16) / 2;
    return (h % 2 == 0) ? ~b[k] : b[k];
  endfunction

  // Starts a frame and compares tape_out cycle by cycle against exp_bytes; a stall of
  // 'gap' cycles holding the previous level is expected from cycle stall_c onward.
  task automatic cap(input bit dsel, input int hpc, input int stall_c, input int gap,
                     input bit slow_ce, input string tag);
    int   done_c, cp, wave_err, busy_err, end_err, done_at, done_n;
    logic tp, bs, dn, ur;
    done_c   = exp_bytes.size() * 16 * hpc + gap;
    wave_err = 0;
    busy_err = 0;
    end_err  = 0;
    done_at  = -1;
    done_n   = 0;
    if (dsel) b_start = 1'b1;
    else a_start = 1'b1;
    for (int c = 0; c <= done_c + 2; c++) begin
      @(posedge clk_sys);
      #1;
      a_start = 1'b0;
      b_start = dsel && slow_ce && (c == 100);
      if (dsel && slow_ce && c == 0) b_len = 16'd5;
      b_ce = !slow_ce || (c % 5 == 4);
      tp = dsel ? b_tape : a_tape;
      bs = dsel ? b_busy : a_busy;
      dn = dsel ? b_done : a_done;
      ur = dsel ? b_underrun : a_underrun;
      if (c == 0) chk({tag, "_underrun_cleared"}, ur, 0);
      if (dn === 1'b1) begin
        done_n++;
        if (done_at < 0) done_at = c;
      end
      if (c < done_c) begin
        cp = (c < stall_c) ? c : ((c < stall_c + gap) ? stall_c - 1 : c - gap);
        if (tp !== lvl(cp / hpc)) wave_err++;
        if (bs !== 1'b1) busy_err++;
      end else if (c == done_c) begin
        if (tp !== 1'b0 || bs !== 1'b0) end_err++;
      end
    end
    chk({tag, "_wave_errors"}, wave_err, 0);
    chk({tag, "_busy_errors"}, busy_err, 0);
    chk({tag, "_done_cycle_levels"}, end_err, 0);
    chk({tag, "_done_at"}, done_at, done_c);
    chk({tag, "_done_pulses"}, done_n, 1);
  endtask

  initial begin
    reset   = 1'b1;
    a_ce    = 1'b1;
    b_ce    = 1'b1;
    a_start = 1'b0;
    b_start = 1'b0;
    a_base  = '0;
    a_len   = 16'd0;
    b_base  = '0;
    b_len   = 16'd0;
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_underrun", a_underrun, 0);
    chk("rst_mem_rd", a_mem.mem_rd, 0);
    chk("rst_mem_addr", a_mem.mem_addr, 0);
    chk("rst_tape", a_tape, 0);
    chk("rst_b_tape", b_tape, 0);
    chk("rst_b_busy", b_busy, 0);
    reset = 1'b0;
    @(posedge clk_sys);
    #1;

    // Single data byte A5 behind preamble and sync.
    a_lat  = 3;
    a_base = 25'h00000FF;
    a_len  = 16'd1;
    a_log.delete();
    exp_bytes = {8'h00, 8'hE6, 8'hA5};
    cap(1'b0, 2, Never, 0, 1'b0, "t1");
    chk("t1_underrun", a_underrun, 0);
    chk("t1_requests", a_log.size(), 1);

    // Slow RAM: second byte stalls the line for 9 cycles.
    a_lat  = 40;
    a_base = 25'h0000040;
    a_len  = 16'd2;
    exp_bytes = {8'h00, 8'hE6, ram(25'h40), ram(25'h41)};
    cap(1'b0, 2, 96, 9, 1'b0, "t4");
    chk("t4_underrun_sticky", a_underrun, 1);

    // Address wrap with fast RAM; start must clear the sticky underrun.
    a_lat  = 1;
    a_base = 25'h1FFFFFF;
    a_len  = 16'd3;
    a_log.delete();
    exp_bytes = {8'h00, 8'hE6, ram(25'h1FFFFFF), ram(25'h0), ram(25'h1)};
    cap(1'b0, 2, Never, 0, 1'b0, "t3");
    chk("t3_requests", a_log.size(), 3);
    if (a_log.size() == 3) begin
      chk("t3_addr0", a_log[0], 25'h1FFFFFF);
      chk("t3_addr1", a_log[1], 25'h0000000);
      chk("t3_addr2", a_log[2], 25'h0000001);
    end
    chk("t3_underrun", a_underrun, 0);

    // Reset while a data fetch is outstanding; its late ack must be ignored.
    a_lat   = 3;
    a_base  = 25'h0000010;
    a_len   = 16'd3;
    a_start = 1'b1;
    @(posedge clk_sys);
    #1;
    a_start = 1'b0;
    repeat (65) @(posedge clk_sys);
    #1;
    chk("t5_fetch_pending", a_mem.mem_rd, 1);
    reset = 1'b1;
    @(posedge clk_sys);
    #1;
    reset = 1'b0;
    chk("t5_busy", a_busy, 0);
    chk("t5_done", a_done, 0);
    chk("t5_underrun", a_underrun, 0);
    chk("t5_mem_rd", a_mem.mem_rd, 0);
    chk("t5_mem_addr", a_mem.mem_addr, 0);
    chk("t5_tape", a_tape, 0);
    @(posedge clk_sys);
    #1;
    chk("t5_no_done", a_done, 0);
    chk("t5_idle", a_busy, 0);
    exp_bytes = {8'h00, 8'hE6, ram(25'h10), ram(25'h11), ram(25'h12)};
    cap(1'b0, 2, Never, 0, 1'b0, "t5");

    // Zero-length frame: preamble and sync only, never touches RAM.
    exp_bytes = {8'h00, 8'h00, 8'hE6};
    cap(1'b1, 3, Never, 0, 1'b0, "t2");
    chk("t2_no_mem_rd", b_rd_cnt, 0);

    // ce every 5th cycle: 15-cycle half-bits; a start while busy is ignored.
    cap(1'b1, 15, Never, 0, 1'b1, "t6");
    chk("t6_no_mem_rd", b_rd_cnt, 0);
    b_len = 16'd0;
    b_ce  = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
